// File: rtl/icache_miss_ctrl.sv
// Miss handler for the 4-set direct-mapped icache: hit detection, dirty victim
// write-back, 16-beat line refill and release of the fetch stage.
module icache_miss_ctrl #(
   parameter int TAG_W = 24,
   parameter int IDX_W = 2,
   parameter int BEATS = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lookup_valid,
   input  logic [31:0]           lookup_va,
   input  logic [TAG_W-1:0]      lookup_ptag,
   input  logic [TAG_W-1:0]      line_tag,
   input  logic [1:0]            line_meta,
   input  logic [BEATS*32-1:0]   line_data,
   output logic                  hit,
   output logic                  stall,
   output logic                  cache_read_enable,
   output logic                  cache_write_enable,
   output logic [31:0]           cache_va,
   output logic [TAG_W-1:0]      cache_ptag,
   output logic [31:0]           cache_write_data,
   output logic                  cache_valid_data,
   output logic                  cache_dirty_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata
);

   localparam int BEAT_W = $clog2(BEATS);
   localparam int IDX_LO = BEAT_W + 2;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

   state_t                state, state_nxt;
   logic [BEAT_W-1:0]     beat, beat_nxt;
   logic [31:0]           va_q;
   logic [TAG_W-1:0]      ptag_q;
   logic [TAG_W-1:0]      victim_tag;
   logic [BEATS*32-1:0]   victim_data;
   logic [IDX_W-1:0]      idx_q;
   logic                  hit_c;
   logic                  miss;
   logic                  beat_done;

   assign idx_q     = va_q[IDX_LO +: IDX_W];
   assign hit_c     = (state == IDLE) & lookup_valid & line_meta[1] & (line_tag == lookup_ptag);
   assign miss      = (state == IDLE) & lookup_valid & ~hit_c;
   // mem_req is high in exactly these two states, so an ack elsewhere is ignored
   assign beat_done = ((state == WB) | (state == FILL)) & mem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         beat  <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
      end
   end

   // Miss context; only meaningful once a miss has been taken, so no reset needed
   always_ff @(posedge clk) begin
      if (miss) begin
         va_q        <= lookup_va;
         ptag_q      <= lookup_ptag;
         victim_tag  <= line_tag;
         victim_data <= line_data;
      end
   end

   always_comb begin
      state_nxt          = state;
      beat_nxt           = beat;
      hit                = 1'b0;
      stall              = 1'b1;
      cache_read_enable  = 1'b0;
      cache_write_enable = 1'b0;
      cache_va           = va_q;
      cache_ptag         = '0;
      cache_write_data   = '0;
      cache_valid_data   = 1'b0;
      cache_dirty_data   = 1'b0;
      mem_req            = 1'b0;
      mem_we             = 1'b0;
      mem_addr           = '0;
      mem_wdata          = '0;
      case (state)
         IDLE: begin
            cache_read_enable = 1'b1;
            cache_va          = lookup_va;
            hit               = hit_c;
            stall             = miss;
            beat_nxt          = '0;
            if (miss) state_nxt = (line_meta == 2'b11) ? WB : FILL;
         end
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {victim_tag, idx_q, beat, 2'b00};
            mem_wdata = victim_data[{beat, 5'b00000} +: 32];
            if (beat_done) begin
               beat_nxt = beat + 1'b1;
               if (beat == LAST_BEAT) state_nxt = FILL;
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {ptag_q, idx_q, beat, 2'b00};
            if (beat_done) begin
               // Valid only with the final word so a partial line never hits
               cache_write_enable = 1'b1;
               cache_va           = {va_q[31:IDX_LO], beat, 2'b00};
               cache_write_data   = mem_rdata;
               cache_ptag         = ptag_q;
               cache_valid_data   = (beat == LAST_BEAT);
               beat_nxt           = beat + 1'b1;
               if (beat == LAST_BEAT) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Bench for icache_miss_ctrl: cache array and memory models, a transaction-level
// reference checked every cycle, and directed plus random scenarios.
module tb_icache_miss_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          lookup_valid;
   logic [31:0]   lookup_va;
   logic [23:0]   lookup_ptag;
   logic [23:0]   line_tag;
   logic [1:0]    line_meta;
   logic [511:0]  line_data;
   logic          hit, stall, cache_read_enable, cache_write_enable;
   logic [31:0]   cache_va;
   logic [23:0]   cache_ptag;
   logic [31:0]   cache_write_data;
   logic          cache_valid_data, cache_dirty_data;
   logic          mem_req, mem_we;
   logic [31:0]   mem_addr, mem_wdata;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   always #5 clk = ~clk;

   icache_miss_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .lookup_valid(lookup_valid), .lookup_va(lookup_va), .lookup_ptag(lookup_ptag),
      .line_tag(line_tag), .line_meta(line_meta), .line_data(line_data),
      .hit(hit), .stall(stall),
      .cache_read_enable(cache_read_enable), .cache_write_enable(cache_write_enable),
      .cache_va(cache_va), .cache_ptag(cache_ptag), .cache_write_data(cache_write_data),
      .cache_valid_data(cache_valid_data), .cache_dirty_data(cache_dirty_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b at %0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [31:0] memfun(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Cache array model
   logic          arr_valid [4];
   logic          arr_dirty [4];
   logic [23:0]   arr_tag   [4];
   logic [31:0]   arr_data  [4][16];
   int            wr_count;
   logic          set_req, set_valid, set_dirty, set_wtag;
   logic [1:0]    set_idx;
   logic [23:0]   set_tag;
   logic [31:0]   set_seed;
   logic [1:0]    sidx;

   always_comb begin
      sidx      = lookup_va[7:6];
      line_tag  = arr_tag[sidx];
      line_meta = {arr_valid[sidx], arr_dirty[sidx]};
      line_data = '0;
      for (int i = 0; i < 16; i++) line_data[i*32 +: 32] = arr_data[sidx][i];
   end

   initial begin
      logic          p_we, p_v, p_d;
      logic [31:0]   p_va, p_wd;
      logic [23:0]   p_tag;
      for (int s = 0; s < 4; s++) begin
         arr_valid[s] = 1'b0;
         arr_dirty[s] = 1'b0;
         arr_tag[s]   = '0;
         for (int i = 0; i < 16; i++) arr_data[s][i] = 32'hC0DE_0000 | (s << 8) | i;
      end
      wr_count = 0;
      forever begin
         @(negedge clk);
         p_we = cache_write_enable & rst_n;
         p_va = cache_va; p_wd = cache_write_data; p_tag = cache_ptag;
         p_v = cache_valid_data; p_d = cache_dirty_data;
         @(posedge clk);
         if (p_we) begin
            arr_data[p_va[7:6]][p_va[5:2]] <= p_wd;
            arr_tag[p_va[7:6]]             <= p_tag;
            arr_valid[p_va[7:6]]           <= p_v;
            arr_dirty[p_va[7:6]]           <= p_d;
            wr_count++;
         end
         if (set_req) begin
            arr_valid[set_idx] <= set_valid;
            arr_dirty[set_idx] <= set_dirty;
            if (set_wtag) begin
               arr_tag[set_idx] <= set_tag;
               for (int i = 0; i < 16; i++) arr_data[set_idx][i] <= set_seed + i;
            end
         end
      end
   end

   // Memory responder: 0 ack every req cycle, 1 every third, 2 random with spurious acks, 3 always
   int ack_mode;
   initial begin
      int  bp;
      logic a;
      bp = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         a = 1'b0;
         if (!mem_req) bp = 0;
         case (ack_mode)
            0: a = mem_req;
            1: if (mem_req) begin bp++; a = (bp % 3 == 0); end
            2: a = mem_req ? ($urandom_range(0, 4) < 3) : ($urandom_range(0, 9) == 0);
            default: a = 1'b1;
         endcase
         mem_ack   = a;
         mem_rdata = a ? memfun(mem_addr) : $urandom;
      end
   end

   // Reference: a miss expands into the list of bus beats and cache writes it must produce
   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
   typedef struct { logic [31:0] va; logic [31:0] data; logic valid; logic [23:0] ptag; } cw_t;
   beat_t bq[$];
   cw_t   cq[$];
   bit    busy;

   initial begin
      logic [1:0]  s;
      logic        eh;
      logic [31:0] m_va;
      beat_t       b;
      cw_t         c;
      busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 1'b0;
            bq.delete();
            cq.delete();
            chk1("rst_mem_req", mem_req, 1'b0);
            chk1("rst_cache_we", cache_write_enable, 1'b0);
         end else if (!busy) begin
            s  = lookup_va[7:6];
            eh = lookup_valid && arr_valid[s] && (arr_tag[s] == lookup_ptag);
            chk1("hit", hit, eh);
            chk1("stall", stall, lookup_valid && !eh);
            chk1("idle_mem_req", mem_req, 1'b0);
            chk1("idle_cache_we", cache_write_enable, 1'b0);
            chk1("idle_read_en", cache_read_enable, 1'b1);
            chk("idle_cache_va", cache_va, lookup_va);
            if (lookup_valid && !eh) begin
               if (arr_valid[s] && arr_dirty[s]) begin
                  for (int i = 0; i < 16; i++) begin
                     b.we = 1'b1; b.addr = {arr_tag[s], s, 4'(i), 2'b00}; b.wdata = arr_data[s][i];
                     bq.push_back(b);
                  end
               end
               for (int i = 0; i < 16; i++) begin
                  b.we = 1'b0; b.addr = {lookup_ptag, s, 4'(i), 2'b00}; b.wdata = '0;
                  bq.push_back(b);
                  c.va = {lookup_va[31:6], 4'(i), 2'b00}; c.data = memfun(b.addr);
                  c.valid = (i == 15); c.ptag = lookup_ptag;
                  cq.push_back(c);
               end
               m_va = lookup_va;
               busy = 1'b1;
            end
         end else begin
            chk1("busy_stall", stall, 1'b1);
            chk1("busy_hit", hit, 1'b0);
            if (bq.size() > 0) begin
               chk1("mem_req", mem_req, 1'b1);
               chk1("mem_we", mem_we, bq[0].we);
               chk("mem_addr", mem_addr, bq[0].addr);
               if (bq[0].we) chk("mem_wdata", mem_wdata, bq[0].wdata);
               if (mem_ack && !bq[0].we) begin
                  chk1("fill_we", cache_write_enable, 1'b1);
                  chk("fill_va", cache_va, cq[0].va);
                  chk("fill_data", cache_write_data, cq[0].data);
                  chk1("fill_valid", cache_valid_data, cq[0].valid);
                  chk1("fill_dirty", cache_dirty_data, 1'b0);
                  chk("fill_ptag", 32'(cache_ptag), 32'(cq[0].ptag));
                  void'(cq.pop_front());
               end else begin
                  chk1("no_cache_we", cache_write_enable, 1'b0);
               end
               if (mem_ack) void'(bq.pop_front());
            end else begin
               chk1("done_mem_req", mem_req, 1'b0);
               chk1("done_cache_we", cache_write_enable, 1'b0);
               chk("done_cache_va", cache_va, m_va);
               busy = 1'b0;
            end
         end
      end
   end

   // Stimulus
   logic [31:0] rec_addr [64];
   logic [31:0] rec_wd   [64];
   logic        rec_we   [64];
   logic        rec_req  [64];
   logic        rec_stall0;

   task automatic setup(input logic [1:0] idx, input logic v, input logic d,
                        input logic [23:0] tag, input logic [31:0] seed);
      @(posedge clk); #1;
      set_idx = idx; set_valid = v; set_dirty = d; set_wtag = 1'b1;
      set_tag = tag; set_seed = seed; set_req = 1'b1;
      @(posedge clk); #1;
      set_req = 1'b0;
   endtask

   task automatic access(input logic [31:0] va, input logic [23:0] pt, output int n);
      @(posedge clk); #1;
      lookup_valid = 1'b1; lookup_va = va; lookup_ptag = pt;
      #2;
      n = 0;
      rec_stall0 = stall;
      while (stall && n < 300) begin
         @(posedge clk); #3;
         n++;
         if (n < 64) begin
            rec_addr[n] = mem_addr; rec_wd[n] = mem_wdata; rec_we[n] = mem_we; rec_req[n] = mem_req;
         end
      end
      if (stall) chk1("access_timeout", stall, 1'b0);
   endtask

   initial begin
      int          n, w0;
      logic [7:0]  t8;
      rst_n = 1'b0; lookup_valid = 1'b0; lookup_va = '0; lookup_ptag = '0;
      ack_mode = 0; set_req = 1'b0; set_idx = '0; set_valid = 1'b0; set_dirty = 1'b0;
      set_wtag = 1'b0; set_tag = '0; set_seed = '0;
      repeat (2) @(posedge clk);
      #1;
      chk1("reset_mem_req", mem_req, 1'b0);
      chk1("reset_mem_we", mem_we, 1'b0);
      chk1("reset_cache_we", cache_write_enable, 1'b0);
      chk1("reset_valid_data", cache_valid_data, 1'b0);
      chk1("reset_dirty_data", cache_dirty_data, 1'b0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      chk1("reset_read_en", cache_read_enable, 1'b1);
      chk1("reset_stall", stall, 1'b0);
      rst_n = 1'b1;

      // Hit on a valid line
      setup(2'd1, 1'b1, 1'b0, 24'h00ABCD, 32'hA000_0000);
      access(32'h00ABCD48, 24'h00ABCD, n);
      chk("hit_penalty", n, 0);
      chk1("hit_out", hit, 1'b1);
      repeat (3) @(posedge clk);

      // Clean miss, ack every cycle
      access(32'h12345680, 24'h123456, n);
      chk("clean_penalty", n, 18);
      chk("clean_addr0", rec_addr[1], 32'h12345680);
      chk1("clean_we0", rec_we[1], 1'b0);
      chk("clean_addr15", rec_addr[16], 32'h123456BC);
      chk1("clean_replay_hit", hit, 1'b1);

      // Dirty victim: 16 write-backs then 16 refills
      setup(2'd0, 1'b1, 1'b1, 24'h000111, 32'hD000_0000);
      access(32'h00022200, 24'h000222, n);
      chk("dirty_penalty", n, 34);
      chk("dirty_wb_addr0", rec_addr[1], 32'h00011100);
      chk1("dirty_wb_we0", rec_we[1], 1'b1);
      chk("dirty_wb_data0", rec_wd[1], 32'hD000_0000);
      chk("dirty_wb_addr15", rec_addr[16], 32'h0001113C);
      chk("dirty_wb_data15", rec_wd[16], 32'hD000_000F);
      chk("dirty_fill_addr0", rec_addr[17], 32'h00022200);
      chk1("dirty_fill_we0", rec_we[17], 1'b0);
      chk1("dirty_no_gap", rec_req[17], 1'b1);

      // Backpressure: ack every third request cycle
      ack_mode = 1;
      w0 = wr_count;
      access(32'h00BEEFC4, 24'h00BEEF, n);
      chk("bp_penalty", n, 50);
      chk("bp_write_count", wr_count - w0, 16);

      // Spurious acks while idle
      ack_mode = 3;
      @(posedge clk); #1;
      lookup_valid = 1'b0;
      w0 = wr_count;
      repeat (5) @(posedge clk);
      #3;
      chk("spurious_writes", wr_count - w0, 0);
      ack_mode = 0;
      access(32'h00CAFEC4, 24'h00CAFE, n);
      chk("post_spurious_addr0", rec_addr[1], 32'h00CAFEC0);
      chk("post_spurious_penalty", n, 18);

      // Reset after five refill beats
      @(posedge clk); #1;
      lookup_valid = 1'b1; lookup_va = 32'h77777780; lookup_ptag = 24'h777777;
      w0 = wr_count;
      repeat (6) @(posedge clk);
      #3;
      lookup_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk1("rst_fill_mem_req", mem_req, 1'b0);
      chk1("rst_fill_cache_we", cache_write_enable, 1'b0);
      chk("rst_fill_writes", wr_count - w0, 5);
      @(posedge clk); #1;
      rst_n = 1'b1;
      access(32'h77777780, 24'h777777, n);
      chk1("rst_remiss_stall", rec_stall0, 1'b1);
      chk("rst_remiss_penalty", n, 18);

      // Random traffic
      ack_mode = 2;
      for (int k = 0; k < 2500; k++) begin
         @(posedge clk); #1;
         t8 = 8'($urandom_range(1, 3));
         lookup_valid = ($urandom_range(0, 4) != 0);
         lookup_va    = {16'h0001, t8, 8'($urandom)};
         lookup_ptag  = ($urandom_range(0, 7) == 0) ? {16'h0001, t8 ^ 8'h01} : {16'h0001, t8};
         set_req   = ($urandom_range(0, 39) == 0);
         set_idx   = 2'($urandom);
         set_valid = 1'($urandom);
         set_dirty = 1'($urandom);
         set_wtag  = 1'($urandom);
         set_tag   = {16'h0001, 8'($urandom_range(1, 3))};
         set_seed  = $urandom;
      end
      @(posedge clk); #1;
      set_req = 1'b0;
      lookup_valid = 1'b0;
      ack_mode = 0;
      n = 0;
      while (busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk1("drain_idle", busy, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
